// File: rtl/pa_strobed_in.sv
// Port A strobed input (8255A mode 1 input / mode 0 basic input).
// Latency: STB_n/PAInRd pin edge to IBF/INTR change is SYNC_STAGES+1 clk edges; mode 0 pin to Dout is SYNC_STAGES edges.
// Backpressure: no flow control toward the peripheral beyond IBF; a strobe into a full buffer overwrites it and sets OVR.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   mode              0 = basic input, 1 = strobed input
//   PAIn[7:0]         port A pins (asynchronous)
//   STB_n             peripheral strobe, active-low (asynchronous)
//   PAInRd            CPU read of port A, active-low (asynchronous)
//   INTESet/INTEVal   one-cycle load of the interrupt enable
//   Dout[7:0]         byte toward the data-bus buffer
//   IBF, INTR, INTE   input buffer full, interrupt request, interrupt enable
//   OVR               sticky overrun, cleared when the buffer is read out
module pa_strobed_in #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode,
  input  logic [7:0] PAIn,
  input  logic       STB_n,
  input  logic       PAInRd,
  input  logic       INTESet,
  input  logic       INTEVal,
  output logic [7:0] Dout,
  output logic       IBF,
  output logic       INTR,
  output logic       INTE,
  output logic       OVR
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    STROBE = 2'd1,
    FULL   = 2'd2,
    READ   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers plus one delayed copy of each strobe for edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] stb_sync;
  logic [SYNC_STAGES-1:0] rd_sync;
  logic [7:0]             pa_sync [SYNC_STAGES];
  logic                   stb_d;
  logic                   rd_d;

  logic                   stb_s;
  logic                   rd_s;
  logic [7:0]             pa_s;

  assign stb_s = stb_sync[SYNC_STAGES-1];
  assign rd_s  = rd_sync[SYNC_STAGES-1];
  assign pa_s  = pa_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stb_sync <= '1;
      rd_sync  <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        pa_sync[i] <= 8'h00;
      end
      stb_d <= 1'b1;
      rd_d  <= 1'b1;
    end else begin
      stb_sync   <= {stb_sync[SYNC_STAGES-2:0], STB_n};
      rd_sync    <= {rd_sync[SYNC_STAGES-2:0], PAInRd};
      pa_sync[0] <= PAIn;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        pa_sync[i] <= pa_sync[i-1];
      end
      stb_d <= stb_s;
      rd_d  <= rd_s;
    end
  end

  logic stb_fall;
  logic rd_fall;
  logic rd_rise;

  assign stb_fall = stb_d & ~stb_s;
  assign rd_fall  = rd_d & ~rd_s;
  assign rd_rise  = ~rd_d & rd_s;

  // ---------------------------------------------------------------------------
  // Handshake state machine
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [7:0] latch_q, latch_d;
  logic       pend_q, pend_d;
  logic       ibf_d;
  logic       ovr_d;
  logic       mode_q;
  logic       mode_chg;

  assign mode_chg = mode ^ mode_q;

  always_comb begin
    state_d = state_q;
    latch_d = latch_q;
    pend_d  = pend_q;
    ibf_d   = IBF;
    ovr_d   = OVR;

    if (!mode || mode_chg) begin
      // Mode 0 holds the handshake idle; any mode change restarts it.
      // The latch is deliberately left alone.
      state_d = EMPTY;
      ibf_d   = 1'b0;
      pend_d  = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          // Level-sensed so a strobe that collided with a read is picked up
          // as soon as the read completes.
          if (!stb_s) begin
            state_d = STROBE;
            latch_d = pa_s;
            ibf_d   = 1'b1;
          end
        end
        STROBE: begin
          if (!stb_s) begin
            latch_d = pa_s;
          end else begin
            // STB was low on entry, so high here is the rising edge.
            state_d = FULL;
            pend_d  = 1'b1;
          end
        end
        FULL: begin
          if (rd_fall) begin
            // Read wins over a simultaneous strobe.
            state_d = READ;
            pend_d  = 1'b0;
          end else if (stb_fall) begin
            state_d = STROBE;
            latch_d = pa_s;
            ovr_d   = 1'b1;
          end
        end
        READ: begin
          if (rd_rise) begin
            state_d = EMPTY;
            ibf_d   = 1'b0;
            ovr_d   = 1'b0;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      latch_q <= 8'h00;
      pend_q  <= 1'b0;
      IBF     <= 1'b0;
      OVR     <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      latch_q <= latch_d;
      pend_q  <= pend_d;
      IBF     <= ibf_d;
      OVR     <= ovr_d;
      mode_q  <= mode;
    end
  end

  // Interrupt enable is a plain loadable bit, independent of the handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      INTE <= 1'b0;
    end else if (INTESet) begin
      INTE <= INTEVal;
    end
  end

  // Masking INTE leaves pend_q intact, so re-enabling re-raises INTR.
  assign INTR = pend_q & INTE;
  assign Dout = mode ? latch_q : pa_s;

endmodule

// File: tb/tb_pa_strobed_in.sv
module tb_pa_strobed_in;

  logic       clk;
  logic       reset;
  logic       mode;
  logic [7:0] PAIn;
  logic       STB_n;
  logic       PAInRd;
  logic       INTESet;
  logic       INTEVal;
  logic [7:0] Dout;
  logic       IBF;
  logic       INTR;
  logic       INTE;
  logic       OVR;

  int compared = 0;
  int mismatched = 0;

  pa_strobed_in #(.SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .mode    (mode),
    .PAIn    (PAIn),
    .STB_n   (STB_n),
    .PAInRd  (PAInRd),
    .INTESet (INTESet),
    .INTEVal (INTEVal),
    .Dout    (Dout),
    .IBF     (IBF),
    .INTR    (INTR),
    .INTE    (INTE),
    .OVR     (OVR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, landing 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic strobe_byte(input logic [7:0] b);
    PAIn  = b;
    STB_n = 1'b0;
    tick(4);
    STB_n = 1'b1;
    tick(4);
  endtask

  task automatic read_pulse();
    PAInRd = 1'b0;
    tick(4);
    PAInRd = 1'b1;
    tick(4);
  endtask

  task automatic load_inte(input logic v);
    INTESet = 1'b1;
    INTEVal = v;
    tick(1);
    INTESet = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    mode    = 1'b0;
    PAIn    = 8'h00;
    STB_n   = 1'b1;
    PAInRd  = 1'b1;
    INTESet = 1'b0;
    INTEVal = 1'b0;
    #3;
    chk("rst_dout", Dout, 8'h00);
    chk("rst_ibf",  {7'd0, IBF},  8'h00);
    chk("rst_intr", {7'd0, INTR}, 8'h00);
    chk("rst_inte", {7'd0, INTE}, 8'h00);
    chk("rst_ovr",  {7'd0, OVR},  8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic mode 1 transfer
    mode = 1'b1;
    tick(2);
    load_inte(1'b1);
    chk("inte_set", {7'd0, INTE}, 8'h01);
    PAIn  = 8'hA5;
    STB_n = 1'b0;
    tick(2);
    chk("ibf_2edges", {7'd0, IBF}, 8'h00);
    tick(1);
    chk("ibf_3edges", {7'd0, IBF}, 8'h01);
    tick(1);
    STB_n = 1'b1;
    tick(2);
    chk("intr_2edges", {7'd0, INTR}, 8'h00);
    tick(1);
    chk("intr_3edges", {7'd0, INTR}, 8'h01);
    chk("dout_a5", Dout, 8'hA5);
    PAInRd = 1'b0;
    tick(3);
    chk("rd_intr_clr", {7'd0, INTR}, 8'h00);
    chk("rd_ibf_held", {7'd0, IBF},  8'h01);
    tick(1);
    PAInRd = 1'b1;
    tick(2);
    chk("rd_ibf_2edges", {7'd0, IBF}, 8'h01);
    tick(1);
    chk("rd_ibf_clr", {7'd0, IBF}, 8'h00);
    chk("rd_ovr", {7'd0, OVR}, 8'h00);
    tick(1);

    // Overrun
    strobe_byte(8'h3C);
    chk("ovr_first", Dout, 8'h3C);
    chk("ovr_none_yet", {7'd0, OVR}, 8'h00);
    strobe_byte(8'hC3);
    chk("ovr_set", {7'd0, OVR}, 8'h01);
    chk("ovr_dout", Dout, 8'hC3);
    chk("ovr_ibf", {7'd0, IBF}, 8'h01);
    read_pulse();
    chk("ovr_rd_ibf", {7'd0, IBF}, 8'h00);
    chk("ovr_rd_ovr", {7'd0, OVR}, 8'h00);

    // Interrupt masking
    load_inte(1'b0);
    chk("inte_clr", {7'd0, INTE}, 8'h00);
    strobe_byte(8'h11);
    chk("mask_ibf",  {7'd0, IBF},  8'h01);
    chk("mask_intr", {7'd0, INTR}, 8'h00);
    chk("mask_dout", Dout, 8'h11);
    load_inte(1'b1);
    chk("unmask_intr", {7'd0, INTR}, 8'h01);
    read_pulse();
    chk("unmask_rd_intr", {7'd0, INTR}, 8'h00);
    chk("unmask_rd_ibf",  {7'd0, IBF},  8'h00);

    // Read/strobe collision
    strobe_byte(8'h55);
    chk("coll_full", Dout, 8'h55);
    PAIn = 8'h66;
    tick(3);
    PAInRd = 1'b0;
    STB_n  = 1'b0;
    tick(3);
    chk("coll_dout_old", Dout, 8'h55);
    chk("coll_intr", {7'd0, INTR}, 8'h00);
    chk("coll_ibf",  {7'd0, IBF},  8'h01);
    chk("coll_ovr",  {7'd0, OVR},  8'h00);
    tick(1);
    PAInRd = 1'b1;
    tick(3);
    chk("coll_empty_ibf", {7'd0, IBF}, 8'h00);
    tick(1);
    chk("coll_restrobe_ibf", {7'd0, IBF}, 8'h01);
    chk("coll_new_dout", Dout, 8'h66);
    STB_n = 1'b1;
    tick(4);
    chk("coll_final_dout", Dout, 8'h66);
    chk("coll_final_ovr",  {7'd0, OVR},  8'h00);
    chk("coll_final_intr", {7'd0, INTR}, 8'h01);

    // Overrun then mode switch 1 -> 0 while FULL
    strobe_byte(8'h77);
    chk("sw_ovr", {7'd0, OVR}, 8'h01);
    mode = 1'b0;
    tick(1);
    chk("sw_ibf",  {7'd0, IBF},  8'h00);
    chk("sw_intr", {7'd0, INTR}, 8'h00);
    chk("sw_ovr_clr", {7'd0, OVR}, 8'h00);
    chk("m0_dout_old", Dout, 8'h77);

    // Mode 0 pass-through
    PAIn = 8'h7E;
    tick(1);
    chk("m0_dout_1edge", Dout, 8'h77);
    tick(1);
    chk("m0_dout_2edges", Dout, 8'h7E);
    STB_n = 1'b0;
    tick(4);
    chk("m0_ibf",  {7'd0, IBF},  8'h00);
    chk("m0_intr", {7'd0, INTR}, 8'h00);
    STB_n = 1'b1;
    tick(2);

    // Reset mid-strobe
    mode = 1'b1;
    PAIn = 8'h99;
    tick(2);
    STB_n = 1'b0;
    tick(4);
    chk("pre_rst_ibf", {7'd0, IBF}, 8'h01);
    reset = 1'b1;
    #2;
    chk("mid_rst_ibf",  {7'd0, IBF},  8'h00);
    chk("mid_rst_intr", {7'd0, INTR}, 8'h00);
    chk("mid_rst_ovr",  {7'd0, OVR},  8'h00);
    chk("mid_rst_inte", {7'd0, INTE}, 8'h00);
    chk("mid_rst_dout", Dout, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(2);
    chk("post_rst_ibf_2", {7'd0, IBF}, 8'h00);
    tick(1);
    chk("post_rst_ibf_3", {7'd0, IBF}, 8'h01);
    STB_n = 1'b1;
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pa_strobed_in.md
# pa_strobed_in

Port A strobed-input block for the 8255A-compatible peripheral. It receives bytes from an external device on the port A pins under the STB#/IBF handshake (8255 mode 1 input) and raises INTR toward the CPU. It supplies the latched byte to the data-bus buffer on a CPU read of port A. It also supports mode 0 (unlatched basic input). It pairs with the port A output latch as the input direction of the same port.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth for the asynchronous pin inputs (PAIn, STB_n, PAInRd); legal range 2–3.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- mode  in  1  0 = mode 0 basic input, 1 = mode 1 strobed input.
- PAIn  in  8  port A pins from the peripheral.
- STB_n  in  1  peripheral strobe (PC4), active-low.
- PAInRd  in  1  CPU read of port A, active-low (RD#, CS# and A1:A0=00 decoded upstream).
- INTESet  in  1  one-cycle pulse that loads INTEVal into INTE (PC4 bit-set/reset).
- INTEVal  in  1  value written to INTE.
- Dout  out  8  byte to the data-bus buffer.
- IBF  out  1  input buffer full (PC5).
- INTR  out  1  interrupt request (PC3).
- INTE  out  1  interrupt enable, readable in the status word.
- OVR  out  1  sticky overrun flag.

## Operation
- PAIn, STB_n and PAInRd each pass through SYNC_STAGES flops; all logic below uses only the synchronized versions. Edges are detected against a one-cycle delayed copy.
- Reset (asynchronous) drives: state=EMPTY, latch=8'h00, Dout=8'h00, IBF=0, INTR=0, INTE=0, OVR=0, synchronizer flops to idle (STB_n=1, PAInRd=1, PAIn=0).
- Mode 0: Dout = synchronized PAIn every cycle. IBF, INTR pending and OVR are held 0. State is held at EMPTY.
- Mode 1 state machine:
  - EMPTY: when STB low -> STROBE; latch loads PAIn; IBF←1.
  - STROBE: while STB stays low, latch reloads PAIn every cycle. On STB rising -> FULL; pend←1.
  - FULL: latch holds.
    - PAInRd falling -> READ; pend←0.
    - Else STB falling -> STROBE; latch loads; OVR←1.
  - READ: latch holds. PAInRd rising -> EMPTY; IBF←0; OVR←0.
- In mode 1, Dout = latch.
- INTR = pend & INTE. Clearing INTE masks a pending INTR without losing it. Setting INTE later with pend=1 raises INTR.
- Simultaneous PAInRd falling and STB falling in FULL: the read wins. The strobe is not lost: STB is level-sensed, so EMPTY re-enters STROBE on the cycle after READ exits if STB is still low.
- STB activity during READ is ignored until READ exits.
- Any change of mode: state←EMPTY, IBF←0, pend←0, OVR←0. The latch keeps its value.
- INTESet has priority over nothing else. It is independent of the state machine and takes effect on the next edge.

## Timing
- STB_n pin falling -> IBF high: SYNC_STAGES+1 rising edges (3 with the default).
- STB_n pin rising -> INTR high (INTE=1): SYNC_STAGES+1 edges.
- PAInRd falling -> INTR low: SYNC_STAGES+1 edges.
- PAInRd rising -> IBF low: SYNC_STAGES+1 edges.
- Captured byte: the synchronized PAIn value on the last cycle STB is sampled low. PAIn must be stable from SYNC_STAGES+1 cycles before the STB rising edge.
- Mode 0: PAIn pin -> Dout takes SYNC_STAGES edges.
- STB low pulse width and PAInRd low width must each be at least 2 clk periods; shorter pulses may be missed.
- INTESet -> INTE/INTR update: 1 edge.

## Test plan
- Reset mid-strobe: assert reset while STB_n low with IBF=1 -> IBF, INTR, OVR, INTE, Dout all 0 immediately (asynchronous); after release with STB_n still low, IBF rises SYNC_STAGES+1 edges later.
- Basic mode 1 transfer: mode=1, INTE=1, PAIn=8'hA5, STB_n low 4 cycles then high.
  - IBF=1 3 edges after the fall; INTR=1 3 edges after the rise; Dout=8'hA5.
  - A PAInRd low pulse clears INTR, then IBF; OVR stays 0.
- Overrun: byte 8'h3C strobed in and not read, then 8'h C3 strobed -> OVR=1, Dout=8'hC3, IBF stays 1; the following read clears IBF and OVR.
- Interrupt masking: INTE=0 during a strobe of 8'h11 -> INTR stays 0 with IBF=1; INTESet with INTEVal=1 -> INTR=1 one edge later; a read clears it.
- Read/strobe collision: in FULL, PAInRd and STB_n fall on the same clk -> state READ, Dout holds the old byte 8'h55. After PAInRd rises, the new byte 8'h66 is latched, IBF=1 again and OVR=0.
- Mode 0 and mode switch: mode=0, PAIn=8'h7E -> Dout=8'h7E after 2 edges, IBF=0 and INTR=0 regardless of STB_n; switching mode 1->0 while FULL clears IBF, INTR and OVR.
